// File: rtl/mem_wb_stage_pkg.sv
// Shared codes for the MEM/WB stage: load types, write-back sources,
// reset PC.
package mem_wb_stage_pkg;

  typedef enum logic [2:0] {
    DM_WORD  = 3'd0,
    DM_HALF  = 3'd1,
    DM_BYTE  = 3'd2,
    DM_HALFU = 3'd3,
    DM_BYTEU = 3'd4,
    DM_LEFT  = 3'd5,
    DM_RIGHT = 3'd6
  } dm_type_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC8 = 2'd2;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load extraction: sub-word select with sign/zero extension,
// plus the lwl/lwr merge with the old rt value.
module load_ext
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_type,
  input  logic [31:0] rt_old,
  output logic [31:0] ext_data
);

  logic [15:0] h;
  logic [7:0]  b;

  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign b = rdata[{addr_lo, 3'b000} +: 8];

  always_comb begin
    ext_data = rdata;
    case (dm_type)
      DM_HALF:  ext_data = {{16{h[15]}}, h};
      DM_HALFU: ext_data = {16'h0, h};
      DM_BYTE:  ext_data = {{24{b[7]}}, b};
      DM_BYTEU: ext_data = {24'h0, b};
      DM_LEFT: begin
        case (addr_lo)
          2'd0: ext_data = {rdata[7:0], rt_old[23:0]};
          2'd1: ext_data = {rdata[15:0], rt_old[15:0]};
          2'd2: ext_data = {rdata[23:0], rt_old[7:0]};
          default: ext_data = rdata;
        endcase
      end
      DM_RIGHT: begin
        case (addr_lo)
          2'd1: ext_data = {rt_old[31:24], rdata[31:8]};
          2'd2: ext_data = {rt_old[31:16], rdata[31:16]};
          2'd3: ext_data = {rt_old[31:8], rdata[31:24]};
          default: ext_data = rdata;
        endcase
      end
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load extraction, write-back select
// and a retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mem_wb_stage_pkg::RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             M_valid,
  input  logic [31:0]      M_pc,
  input  logic [1:0]       M_addr_lo,
  input  logic [2:0]       M_dm_type,
  input  logic [31:0]      M_rdata,
  input  logic [31:0]      M_rt_old,
  input  logic [31:0]      M_alu_res,
  input  logic [1:0]       M_wb_sel,
  input  logic             M_reg_we,
  input  logic [4:0]       M_reg_addr,
  output logic             W_valid,
  output logic [31:0]      W_pc,
  output logic             W_reg_we,
  output logic [4:0]       W_reg_addr,
  output logic [31:0]      W_wd,
  output logic [CNT_W-1:0] retire_cnt
);

  logic        valid;
  logic [31:0] pc;
  logic [1:0]  addr_lo;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic [31:0] rt_old;
  logic [31:0] alu_res;
  logic [1:0]  wb_sel;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] ext_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid    <= 1'b0;
      pc       <= RESET_PC;
      addr_lo  <= 2'd0;
      dm_type  <= DM_WORD;
      rdata    <= 32'h0;
      rt_old   <= 32'h0;
      alu_res  <= 32'h0;
      wb_sel   <= WB_ALU;
      reg_we   <= 1'b0;
      reg_addr <= 5'd0;
    end else if (en) begin
      valid    <= M_valid;
      pc       <= M_pc;
      addr_lo  <= M_addr_lo;
      dm_type  <= M_dm_type;
      rdata    <= M_rdata;
      rt_old   <= M_rt_old;
      alu_res  <= M_alu_res;
      wb_sel   <= M_wb_sel;
      reg_we   <= M_reg_we;
      reg_addr <= M_reg_addr;
    end
  end

  // Flush squashes the bubble but keeps the count of what already retired.
  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= '0;
    else if (!flush && en && M_valid)
      retire_cnt <= retire_cnt + CNT_W'(1);
  end

  load_ext u_load_ext (
    .rdata    (rdata),
    .addr_lo  (addr_lo),
    .dm_type  (dm_type),
    .rt_old   (rt_old),
    .ext_data (ext_data)
  );

  always_comb begin
    W_wd = alu_res;
    case (wb_sel)
      WB_MEM:  W_wd = ext_data;
      WB_PC8:  W_wd = pc + 32'd8;
      default: W_wd = alu_res;
    endcase
  end

  assign W_valid    = valid;
  assign W_pc       = pc;
  assign W_reg_addr = reg_addr;
  assign W_reg_we   = reg_we & valid & (reg_addr != 5'd0);

endmodule
